// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-stage LSU; pipeline req/we/funct3/addr/wdata in, stall/valid/load_data/misalign/bus_err out, single dbus transaction with byte enables and timeout
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic is_half, is_word, legal, misal, ok, timeout;
  logic [3:0] be;
  logic [31:0] lanes, shifted, ext;
  always_comb begin
    is_half = funct3_i[1:0] == 2'b01;
    is_word = funct3_i[1:0] == 2'b10;
    legal = mem_we_i ? funct3_i inside {3'b000, 3'b001, 3'b010} : !(funct3_i inside {3'b011, 3'b110, 3'b111});
    misal = (is_half & addr_i[0]) | (is_word & |addr_i[1:0]);
    ok = legal & ~misal;
    be = !mem_we_i || is_word ? 4'b1111 : is_half ? 4'b0011 << addr_i[1:0] : 4'b0001 << addr_i[1:0];
    lanes = is_word ? wdata_i : is_half ? {2{wdata_i[15:0]}} : {4{wdata_i[7:0]}};
    shifted = dbus_rdata_i >> {off_q, 3'b000};
    ext = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]} :
          f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]} : shifted;
    timeout = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));
    state_n = state == IDLE ? (mem_req_i ? (ok ? BUS : DONE) : IDLE) :
              state == BUS  ? (dbus_ack_i || timeout ? DONE : BUS) : IDLE;
    stall_o = (state == IDLE && mem_req_i) || state == BUS;
    valid_o = state == DONE;
    dbus_req_o = state == BUS;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      f3_q <= '0;
      off_q <= '0;
      dbus_we_o <= 1'b0;
      dbus_addr_o <= '0;
      dbus_be_o <= '0;
      dbus_wdata_o <= '0;
      load_data_o <= '0;
      misalign_o <= 1'b0;
      bus_err_o <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && mem_req_i) begin
        misalign_o <= legal & misal;
        bus_err_o <= ~legal;
        if (ok) begin
          cnt <= '0;
          f3_q <= funct3_i;
          off_q <= addr_i[1:0];
          dbus_we_o <= mem_we_i;
          dbus_addr_o <= {addr_i[31:2], 2'b00};
          dbus_be_o <= be;
          dbus_wdata_o <= lanes;
        end
      end
      if (state == BUS) begin
        cnt <= cnt + 1'b1;
        if (dbus_ack_i && !dbus_we_o) load_data_o <= ext;
        if (!dbus_ack_i && timeout) bus_err_o <= 1'b1;
      end
      if (state == DONE) begin
        misalign_o <= 1'b0;
        bus_err_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench for load_store_unit against a byte-level reference model
module tb_load_store_unit;
  localparam int TO = 4;
  logic clk = 0, rst_i = 1;
  logic mem_req_i = 0, mem_we_i = 0, dbus_ack_i = 0;
  logic [2:0] funct3_i = 0;
  logic [31:0] addr_i = 0, wdata_i = 0, dbus_rdata_i = 0;
  logic stall_o, valid_o, misalign_o, bus_err_o, dbus_req_o, dbus_we_o;
  logic [31:0] load_data_o, dbus_addr_o, dbus_wdata_o;
  logic [3:0] dbus_be_o;
  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o),
    .valid_o(valid_o), .load_data_o(load_data_o), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
    .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic bus, we, mis, err;
    logic [31:0] addr, wd, ld;
    logic [3:0] be;
    int stall, reqc;
  } exp_t;
  exp_t q[$];
  int n_checks = 0, n_fail = 0, sc = 0, rc = 0, r_wait = 0;
  logic force_ack = 0;
  logic [31:0] prev_ld = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] a, wd, rd, input int wt, input logic [31:0] prev);
    exp_t e;
    int size, off;
    logic legal;
    longint v;
    size = f3[1:0] == 0 ? 1 : f3[1:0] == 1 ? 2 : 4;
    off = int'(a % 4);
    legal = we ? (f3 == 0 || f3 == 1 || f3 == 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    e.we = we;
    e.mis = legal && (off % size != 0);
    e.bus = legal && !e.mis;
    e.err = !legal || (e.bus && wt >= TO);
    e.addr = a - (a % 4);
    for (int i = 0; i < 4; i++) begin
      e.be[i] = we ? (i >= off && i < off + size) : 1'b1;
      e.wd[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    e.ld = prev;
    if (e.bus && !we && wt < TO) begin
      v = longint'(rd) >> (8 * off);
      v = v % (64'sd1 << (8 * size));
      if (f3[2] == 0 && size < 4 && v >= (64'sd1 << (8 * size - 1))) v = v - (64'sd1 << (8 * size));
      e.ld = v[31:0];
    end
    e.stall = !e.bus ? 1 : wt >= TO ? 1 + TO : 2 + wt;
    e.reqc = !e.bus ? 0 : wt >= TO ? TO : wt + 1;
    return e;
  endfunction
  initial begin
    int w;
    w = 0;
    forever begin
      @(negedge clk);
      if (dbus_req_o) begin
        dbus_ack_i = (w == r_wait);
        w++;
      end else begin
        dbus_ack_i = force_ack;
        w = 0;
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      chk("reset_outputs", {30'd0, dbus_req_o, dbus_we_o}, 32'd0);
      chk("reset_addr_wdata", dbus_addr_o | dbus_wdata_o | {28'd0, dbus_be_o}, 32'd0);
      chk("reset_flags_ld", load_data_o | {29'd0, valid_o, misalign_o, bus_err_o}, 32'd0);
      chk("reset_stall", {31'd0, stall_o}, {31'd0, mem_req_i});
      q.delete();
      sc = 0;
      rc = 0;
    end else begin
      if (stall_o) sc++;
      if (dbus_req_o) begin
        rc++;
        if (q.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
        else if (q[0].bus) begin
          chk("bus_addr", dbus_addr_o, q[0].addr);
          chk("bus_we", {31'd0, dbus_we_o}, {31'd0, q[0].we});
          chk("bus_be", {28'd0, dbus_be_o}, {28'd0, q[0].be});
          if (q[0].we) chk("bus_wdata", dbus_wdata_o, q[0].wd);
        end
      end
      if (valid_o) begin
        if (q.size() == 0) chk("valid_unexpected", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("misalign", {31'd0, misalign_o}, {31'd0, e.mis});
          chk("bus_err", {31'd0, bus_err_o}, {31'd0, e.err});
          chk("load_data", load_data_o, e.ld);
          chk("stall_cycles", sc, e.stall);
          chk("req_cycles", rc, e.reqc);
        end
        sc = 0;
        rc = 0;
      end
    end
  end
  task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] a, wd, rd, input int wt);
    exp_t e;
    int n;
    e = model(we, f3, a, wd, rd, wt, prev_ld);
    prev_ld = e.ld;
    q.push_back(e);
    r_wait = wt;
    force_ack = 0;
    dbus_rdata_i = rd;
    mem_we_i = we;
    funct3_i = f3;
    addr_i = a;
    wdata_i = wd;
    mem_req_i = 1;
    n = 0;
    @(negedge clk);
    while (stall_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      $display("FAIL stall_timeout actual=%0d expected=%0d", n, e.stall);
      $fatal(1, "stall never released");
    end
    @(posedge clk);
    #1 mem_req_i = 0;
  endtask
  task automatic gap(input int g);
    repeat (g) begin
      force_ack = 1'($urandom);
      @(posedge clk);
      #1;
    end
    force_ack = 0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    @(posedge clk);
    #1;
    op(0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
    op(0, 3'b101, 32'h0000_2002, 32'h0, 32'h80FF_1234, 3);
    op(1, 3'b001, 32'h0000_3002, 32'hDEAD_BEEF, 32'h1111_1111, 0);
    op(0, 3'b010, 32'h0000_4001, 32'h0, 32'h2222_2222, 0);
    op(0, 3'b010, 32'h0000_4000, 32'h0, 32'h3333_3333, 1000);
    op(0, 3'b010, 32'h0000_4004, 32'h0, 32'h4444_4444, TO - 1);
    q.push_back(model(0, 3'b010, 32'h0000_6000, 0, 0, 1000, prev_ld));
    r_wait = 1000;
    mem_we_i = 0;
    funct3_i = 3'b010;
    addr_i = 32'h0000_6000;
    mem_req_i = 1;
    repeat (3) @(posedge clk);
    #2 rst_i = 1;
    mem_req_i = 0;
    @(negedge clk);
    #1 rst_i = 0;
    prev_ld = 0;
    force_ack = 1;
    repeat (3) @(posedge clk);
    #1 force_ack = 0;
    op(1, 3'b000, 32'h0000_5001, 32'h0000_00AB, 32'h0, 0);
    op(0, 3'b011, 32'h0000_7000, 32'h0, 32'h5555_5555, 0);
    op(1, 3'b100, 32'h0000_7000, 32'h1234_5678, 32'h0, 0);
    op(0, 3'b100, 32'h0000_7002, 32'h0, 32'h00C3_0000, 1);
    for (int i = 0; i < 300; i++) begin
      op(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 5));
      gap($urandom_range(0, 2));
    end
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit for the RV32I core's memory stage. It turns a load/store request from the pipeline into a single data-bus transaction with byte enables. It stalls the pipeline until the transaction completes, then returns aligned, sign/zero-extended load data. `load_data_o` feeds the writeback result select (select code 3'b001) that chooses between ALU, load, PC+4, immediate and AUIPC results.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum BUS-state cycles to wait for `dbus_ack_i`; 0 disables the timeout.
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `mem_req_i`  in  1  memory-stage instruction is a load/store; held until `stall_o` falls.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `funct3_i`  in  3  RV32I funct3 (width/signedness).
- `addr_i`  in  32  effective byte address.
- `wdata_i`  in  32  store data (rs2).
- `stall_o`  out  1  freeze pipeline (combinational).
- `valid_o`  out  1  one-cycle completion pulse.
- `load_data_o`  out  32  extended load result (registered).
- `misalign_o`  out  1  misaligned-access flag, valid with `valid_o`.
- `bus_err_o`  out  1  illegal funct3 or timeout, valid with `valid_o`.
- `dbus_req_o`  out  1  bus request.
- `dbus_we_o`  out  1  bus write.
- `dbus_addr_o`  out  32  word address, {addr_i[31:2],2'b00}.
- `dbus_be_o`  out  4  byte enables.
- `dbus_wdata_o`  out  32  lane-replicated store data.
- `dbus_rdata_i`  in  32  read data, valid with ack.
- `dbus_ack_i`  in  1  transaction complete.

## Operation
- FSM states: IDLE, BUS, DONE. Reset state is IDLE.
- IDLE, when `mem_req_i`=1:
  - Legal and aligned: latch the bus fields and the load control (funct3, addr[1:0]), then go to BUS.
  - Misaligned or illegal: set `misalign_o`/`bus_err_o` and go straight to DONE. No bus cycle is issued.
- BUS:
  - `dbus_req_o`=1, with all `dbus_*` outputs stable.
  - On `dbus_ack_i`: capture the extended load data, drop the request, go to DONE.
  - If the wait counter reaches `TIMEOUT_CYCLES` first: drop the request, set `bus_err_o`, go to DONE.
- DONE: `valid_o`=1 for one cycle, then always return to IDLE. `mem_req_i` is ignored in DONE because it still belongs to the completing instruction.
- Alignment rules:
  - Halfword accesses are misaligned when addr[0]=1.
  - Word accesses are misaligned when addr[1:0]≠0.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: anything other than 000, 001, 010.
- Store byte enables, with off=addr[1:0]:
  - SB: 4'b0001<<off.
  - SH: 4'b0011<<off.
  - SW: 4'b1111.
- Store data lanes:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Loads: `dbus_be_o`=4'b1111. The byte or halfword is selected by the latched off and extended:
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- Stores leave `load_data_o` unchanged.
- `dbus_ack_i` outside BUS is ignored.

## Timing
- `stall_o` = (IDLE & `mem_req_i`) | BUS. It is low in DONE, so the pipeline advances on the DONE edge.
- With ack in the first BUS cycle: IDLE accept (cycle 0), BUS with ack (cycle 1), DONE with `valid_o` (cycle 2).
  - `stall_o` is high for 2 cycles.
  - Every extra ack wait cycle adds one stall cycle.
- Misaligned or illegal access: `stall_o` high for 1 cycle, `valid_o` in the next cycle, `dbus_req_o` never asserted.
- Timeout: `valid_o` with `bus_err_o`=1 in the cycle after the BUS cycle in which the counter reaches `TIMEOUT_CYCLES`. The counter clears on entering BUS.
- `misalign_o` and `bus_err_o` are meaningful only while `valid_o`=1. They are cleared on the transition from DONE back to IDLE.
- Reset (asynchronous, any state, including mid-BUS):
  - FSM returns to IDLE.
  - All outputs go to 0: `dbus_req_o`, `dbus_we_o`, `dbus_addr_o`, `dbus_be_o`, `dbus_wdata_o`, `valid_o`, `load_data_o`, `misalign_o`, `bus_err_o`, counter.
  - `stall_o` then follows `mem_req_i` combinationally.
  - An outstanding bus transaction is abandoned; a late ack arrives in IDLE and is ignored.

## Test plan
- LB at 0x1003, `dbus_rdata_i`=0x80FF_1234, ack on the first BUS cycle -> `dbus_addr_o`=0x1000, `dbus_be_o`=4'b1111; `load_data_o`=0xFFFF_FF80 with `valid_o` at cycle 2; `stall_o` high for exactly 2 cycles.
- LHU at 0x2002 with the same rdata, ack after 3 wait cycles -> `load_data_o`=0x0000_80FF; `stall_o` high for 5 cycles.
- SH at 0x3002, `wdata_i`=0xDEAD_BEEF -> `dbus_we_o`=1, `dbus_be_o`=4'b1100, `dbus_wdata_o`=0xBEEF_BEEF; `load_data_o` unchanged.
- LW at 0x4001 -> no `dbus_req_o`; `valid_o` with `misalign_o`=1 one cycle after the request.
- Load with ack never asserted and `TIMEOUT_CYCLES`=4 -> `dbus_req_o` high for 4 cycles, then `valid_o` with `bus_err_o`=1.
- `rst_i` pulsed mid-BUS, then ack arrives in IDLE -> all outputs 0 and the ack is ignored; a following SB at 0x5001 with `wdata_i`=0x0000_00AB gives `dbus_be_o`=4'b0010, `dbus_wdata_o`=0xABAB_ABAB.
